// File: rtl/light_conflict_monitor.sv
// Conflict monitor between a traffic light controller and the lamps: passes
// legal requests through, and forces a flashing-red fault on conflict, bad encoding or bad sequence.
module light_conflict_monitor #(
  parameter int MIN_YEL    = 3,
  parameter int FLASH_HALF = 4,
  parameter int ALLRED_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in_M1,
  input  logic [2:0] in_S,
  input  logic [2:0] in_M2,
  input  logic [2:0] in_MT,
  input  logic       clr_fault,
  output logic [2:0] out_M1,
  output logic [2:0] out_S,
  output logic [2:0] out_M2,
  output logic [2:0] out_MT,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] fault_cnt
);

  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] DARK = 3'b000;

  localparam int RW = $clog2(ALLRED_CYC + 1);
  localparam int FW = $clog2(2 * FLASH_HALF);
  localparam logic [RW-1:0] REC_LAST   = RW'(ALLRED_CYC - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(2 * FLASH_HALF - 1);
  localparam logic [FW-1:0] FLASH_MID  = FW'(FLASH_HALF);
  localparam logic [7:0]    MIN_YEL_W  = 8'(MIN_YEL);

  typedef enum logic [1:0] {
    RECOVER = 2'd0,
    RUN     = 2'd1,
    FAULT   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Direction index: 0=M1, 1=S, 2=M2, 3=MT
  logic [2:0] lamp_in [4];
  logic [3:0] valid, green, seq_bad, inv_bad;
  logic [2:0] prev_reg [4];
  logic [7:0] ycnt_reg [4];
  logic       inv_reg  [4];
  logic [2:0] out_reg  [4];
  logic [2:0] out_next [4];

  logic [RW-1:0] rec_cnt_reg, rec_cnt_next;
  logic [FW-1:0] flash_cnt_reg, flash_cnt_next;
  logic          conflict, invalid, sequence_err, detect, all_valid, fault_entry;
  logic [1:0]    cause;

  assign lamp_in[0] = in_M1;
  assign lamp_in[1] = in_S;
  assign lamp_in[2] = in_M2;
  assign lamp_in[3] = in_MT;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dir
      assign valid[gi]   = (lamp_in[gi] == RED) || (lamp_in[gi] == YEL) || (lamp_in[gi] == GRN);
      assign green[gi]   = (lamp_in[gi] == GRN);
      // inv_reg remembers a bad encoding last cycle, so one-cycle glitches pass
      assign inv_bad[gi] = !valid[gi] && inv_reg[gi];
      assign seq_bad[gi] = valid[gi] && (
          (prev_reg[gi] == RED && lamp_in[gi] == YEL) ||
          (prev_reg[gi] == GRN && lamp_in[gi] == RED) ||
          (prev_reg[gi] == YEL && lamp_in[gi] == GRN) ||
          (prev_reg[gi] == YEL && lamp_in[gi] == RED && ycnt_reg[gi] < MIN_YEL_W));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          prev_reg[gi] <= RED;
          ycnt_reg[gi] <= 8'd0;
          inv_reg[gi]  <= 1'b0;
        end else begin
          inv_reg[gi] <= !valid[gi];
          if (valid[gi]) begin
            prev_reg[gi] <= lamp_in[gi];
          end
          if (lamp_in[gi] == YEL) begin
            ycnt_reg[gi] <= (ycnt_reg[gi] == 8'hFF) ? ycnt_reg[gi] : ycnt_reg[gi] + 8'd1;
          end else begin
            ycnt_reg[gi] <= 8'd0;
          end
        end
      end
    end
  endgenerate

  assign conflict     = (green[1] && (green[0] || green[2] || green[3])) || (green[3] && green[2]);
  assign invalid      = |inv_bad;
  assign sequence_err = (state_reg == RUN) && (|seq_bad);
  assign detect       = conflict || invalid || sequence_err;
  assign all_valid    = &valid;
  assign cause        = conflict ? 2'b01 : (invalid ? 2'b10 : 2'b11);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RECOVER: begin
        if (detect) begin
          state_next = FAULT;
        end else if (rec_cnt_reg == REC_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (detect) begin
          state_next = FAULT;
        end
      end
      FAULT: begin
        if (clr_fault && all_valid && !conflict) begin
          state_next = RECOVER;
        end
      end
      default: state_next = RECOVER;
    endcase
  end

  assign fault_entry = (state_next == FAULT) && (state_reg != FAULT);

  always_comb begin
    rec_cnt_next   = '0;
    flash_cnt_next = '0;
    if (state_next == RECOVER && state_reg == RECOVER) begin
      rec_cnt_next = rec_cnt_reg + RW'(1);
    end
    // Counter restarts on every FAULT entry, so the flash always opens with red
    if (state_next == FAULT && state_reg == FAULT) begin
      flash_cnt_next = (flash_cnt_reg == FLASH_LAST) ? '0 : flash_cnt_reg + FW'(1);
    end
    for (int i = 0; i < 4; i++) begin
      out_next[i] = RED;
      case (state_next)
        RUN:     out_next[i] = lamp_in[i];
        FAULT:   out_next[i] = (flash_cnt_next < FLASH_MID) ? RED : DARK;
        default: out_next[i] = RED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= RECOVER;
      rec_cnt_reg   <= '0;
      flash_cnt_reg <= '0;
      fault_code    <= 2'b00;
      fault_cnt     <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        out_reg[i] <= RED;
      end
    end else begin
      state_reg     <= state_next;
      rec_cnt_reg   <= rec_cnt_next;
      flash_cnt_reg <= flash_cnt_next;
      if (fault_entry) begin
        fault_code <= cause;
        if (fault_cnt != 8'hFF) begin
          fault_cnt <= fault_cnt + 8'd1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        out_reg[i] <= out_next[i];
      end
    end
  end

  assign out_M1 = out_reg[0];
  assign out_S  = out_reg[1];
  assign out_M2 = out_reg[2];
  assign out_MT = out_reg[3];
  assign fault  = (state_reg == FAULT);

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Bench for light_conflict_monitor: directed scenarios plus random traffic,
// all checked every cycle against a behavioural model of the monitor's rules.
module tb_light_conflict_monitor;

  localparam int MIN_YEL    = 3;
  localparam int FLASH_HALF = 4;
  localparam int ALLRED_CYC = 8;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] D = 3'b000;

  localparam int M_REC = 0, M_RUN = 1, M_FAULT = 2;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [2:0] drv [4];
  logic [2:0] o   [4];
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] fault_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Behavioural model state
  int         m_mode, rec_time, flash_time, m_code, m_cnt;
  logic [2:0] last_valid [4];
  int         yel_run [4];
  int         bad_run [4];
  logic [2:0] m_out [4];

  // Random generator state
  logic [2:0] gen_val [4];
  int         glitch_left [4];
  logic [2:0] bad_vals [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
  logic [2:0] good_vals [3] = '{R, G, Y};

  light_conflict_monitor #(
    .MIN_YEL(MIN_YEL), .FLASH_HALF(FLASH_HALF), .ALLRED_CYC(ALLRED_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_M1(drv[0]), .in_S(drv[1]), .in_M2(drv[2]), .in_MT(drv[3]),
    .clr_fault(clr),
    .out_M1(o[0]), .out_S(o[1]), .out_M2(o[2]), .out_MT(o[3]),
    .fault(fault), .fault_code(fault_code), .fault_cnt(fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit onehot(input logic [2:0] v);
    return $countones(v) == 1;
  endfunction

  // Position in the cycle red -> green -> yellow -> red
  function automatic int phase(input logic [2:0] v);
    return (v == R) ? 0 : ((v == G) ? 1 : 2);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_REC; rec_time = 0; flash_time = 0; m_code = 0; m_cnt = 0;
    for (int d = 0; d < 4; d++) begin
      last_valid[d] = R; yel_run[d] = 0; bad_run[d] = 0; m_out[d] = R;
    end
  endtask

  // Advance the model by one clock edge using the inputs held during that cycle
  task automatic model_update();
    bit g [4];
    bit conf, inv, seq, allv;
    int p, q;
    for (int d = 0; d < 4; d++) g[d] = (drv[d] == G);
    conf = (g[1] && (g[0] || g[2] || g[3])) || (g[3] && g[2]);
    inv = 0; seq = 0; allv = 1;
    for (int d = 0; d < 4; d++) begin
      if (!onehot(drv[d])) begin
        allv = 0;
        if (bad_run[d] >= 1) inv = 1;
      end else if (m_mode == M_RUN) begin
        p = phase(last_valid[d]);
        q = phase(drv[d]);
        if (q != p) begin
          if (q != (p + 1) % 3) seq = 1;
          else if (p == 2 && yel_run[d] < MIN_YEL) seq = 1;
        end
      end
    end
    if (m_mode != M_FAULT && (conf || inv || seq)) begin
      m_mode = M_FAULT; flash_time = 0;
      m_code = conf ? 1 : (inv ? 2 : 3);
      if (m_cnt < 255) m_cnt++;
    end else if (m_mode == M_FAULT) begin
      if (clr && allv && !conf) begin
        m_mode = M_REC; rec_time = 0;
      end else begin
        flash_time++;
      end
    end else if (m_mode == M_REC) begin
      rec_time++;
      if (rec_time == ALLRED_CYC) m_mode = M_RUN;
    end
    for (int d = 0; d < 4; d++) begin
      if (m_mode == M_RUN) m_out[d] = drv[d];
      else if (m_mode == M_REC) m_out[d] = R;
      else m_out[d] = ((flash_time / FLASH_HALF) % 2 == 0) ? R : D;
      if (onehot(drv[d])) last_valid[d] = drv[d];
      yel_run[d] = (drv[d] == Y) ? ((yel_run[d] < 255) ? yel_run[d] + 1 : 255) : 0;
      bad_run[d] = onehot(drv[d]) ? 0 : bad_run[d] + 1;
    end
  endtask

  task automatic check_model();
    for (int d = 0; d < 4; d++) chk($sformatf("model_out%0d", d), o[d], m_out[d]);
    chk("model_fault", fault, (m_mode == M_FAULT) ? 1 : 0);
    chk("model_code", fault_code, m_code);
    chk("model_cnt", fault_cnt, m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_update();
    @(negedge clk);
    check_model();
  endtask

  task automatic set_all(input logic [2:0] v);
    for (int d = 0; d < 4; d++) drv[d] = v;
  endtask

  task automatic clear_and_recover();
    set_all(R);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_fault_low", fault, 0);
    repeat (ALLRED_CYC) step();
  endtask

  task automatic random_cycle();
    int r;
    for (int d = 0; d < 4; d++) begin
      r = $urandom_range(0, 99);
      if (m_mode == M_FAULT && $urandom_range(0, 1) == 0) gen_val[d] = R;
      if (glitch_left[d] > 0) begin
        glitch_left[d]--;
        drv[d] = bad_vals[$urandom_range(0, 4)];
      end else if (r < 3) begin
        glitch_left[d] = $urandom_range(0, 1);
        drv[d] = bad_vals[$urandom_range(0, 4)];
      end else if (r < 5) begin
        gen_val[d] = good_vals[$urandom_range(0, 2)];
        drv[d] = gen_val[d];
      end else if (r < 15) begin
        gen_val[d] = good_vals[(phase(gen_val[d]) + 1) % 3];
        drv[d] = gen_val[d];
      end else begin
        drv[d] = gen_val[d];
      end
    end
    clr = (m_mode == M_FAULT) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 30) == 0);
    step();
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0;
    set_all(R);
    model_reset();
    repeat (2) @(negedge clk);
    check_model();
    chk("rst_out_M1", o[0], R);
    chk("rst_cnt", fault_cnt, 0);
    rst = 1'b1;

    // Release: 8 cycles of all-red, then RUN echoes M1 one cycle later
    repeat (ALLRED_CYC) begin
      step();
      chk("recover_out_S", o[1], R);
    end
    drv[0] = G;
    step();
    chk("run_delay_M1", o[0], G);

    // Conflict S with M1 -> fault, code 01, flash 4 red / 4 dark
    drv[1] = G;
    step();
    drv[1] = R;
    chk("conf_fault", fault, 1);
    chk("conf_code", fault_code, 1);
    chk("conf_cnt", fault_cnt, 1);
    chk("flash_0", o[2], R);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("flash_%0d", i), o[2], (i >= 4 && i < 8) ? D : R);
    end

    // Clear refused while conflicting, accepted on all-red
    drv[1] = G;
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_refused", fault, 1);
    set_all(R);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_accepted", fault, 0);
    chk("code_sticky", fault_code, 1);
    repeat (ALLRED_CYC) step();
    drv[0] = G;
    step();
    chk("rerun_M1", o[0], G);

    // One-cycle invalid glitch is ignored; two cycles fault with code 10
    drv[3] = 3'b011; step(); drv[3] = R;
    chk("glitch_nofault", fault, 0);
    step();
    chk("glitch_nofault2", fault, 0);
    drv[3] = 3'b011; step();
    chk("inv1_nofault", fault, 0);
    step();
    chk("inv2_fault", fault, 1);
    chk("inv_code", fault_code, 2);
    chk("inv_cnt", fault_cnt, 2);
    clear_and_recover();

    // Short yellow on M2 is a sequence fault; full yellow is fine
    drv[2] = G; step();
    drv[2] = Y; step(); step();
    drv[2] = R; step();
    chk("short_yel_fault", fault, 1);
    chk("short_yel_code", fault_code, 3);
    chk("short_yel_cnt", fault_cnt, 3);
    clear_and_recover();
    drv[2] = G; step();
    drv[2] = Y; repeat (MIN_YEL) step();
    drv[2] = R; step();
    chk("full_yel_nofault", fault, 0);
    step();
    chk("full_yel_nofault2", fault, 0);

    // Random traffic
    for (int d = 0; d < 4; d++) begin
      gen_val[d] = drv[d]; glitch_left[d] = 0;
    end
    repeat (3000) random_cycle();

    // Asynchronous reset in the middle of a flash
    clr = 1'b0;
    drv[0] = G; drv[1] = G; step();
    set_all(R); step(); step();
    chk("pre_rst_fault", fault, 1);
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) chk($sformatf("async_rst_out%0d", d), o[d], R);
    chk("async_rst_cnt", fault_cnt, 0);
    chk("async_rst_fault", fault, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    check_model();
    for (int d = 0; d < 4; d++) begin
      gen_val[d] = R; glitch_left[d] = 0;
    end
    repeat (500) random_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/light_conflict_monitor.md
LIGHT_CONFLICT_MONITOR -- requirements
Module: light_conflict_monitor

Interface
REQ-001 The block SHALL use parameter MIN_YEL, default 3: the minimum number of consecutive yellow cycles required before a yellow-to-red transition.
REQ-002 The block SHALL use parameter FLASH_HALF, default 4: the length in cycles of each half-period of the fault flash.
REQ-003 The block SHALL use parameter ALLRED_CYC, default 8: the length in cycles of the all-red recovery hold.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have ports in_M1, in_S, in_M2, in_MT, each input, 3 bits: light requests from the traffic light controller, encoded {red,yellow,green}, so 100=R, 010=Y, 001=G.
REQ-007 The block SHALL have port clr_fault, input, 1 bit: single-cycle operator request to leave the fault state.
REQ-008 The block SHALL have ports out_M1, out_S, out_M2, out_MT, each output, 3 bits: registered lamp drive, same encoding as the inputs.
REQ-009 The block SHALL have port fault, output, 1 bit: high while in the FAULT state.
REQ-010 The block SHALL have port fault_code, output, 2 bits: sticky cause of the last fault; 01=conflict, 10=invalid encoding, 11=sequence.
REQ-011 The block SHALL have port fault_cnt, output, 8 bits: count of FAULT entries, saturating at 255.

Function
REQ-012 The state machine SHALL have exactly three states: RECOVER, RUN and FAULT.
REQ-013 Conflict rule: a conflict SHALL be any cycle in which two conflicting directions are green, where S conflicts with M1, M2 and MT, MT conflicts with M2, and M1 with M2 green together is legal.
REQ-014 Invalid rule: an invalid fault SHALL be raised when any input is not one-hot for 2 or more consecutive cycles; a single-cycle glitch SHALL NOT raise a fault.
REQ-015 Sequence rule (RUN only): per direction, the legal transitions SHALL be R->G, G->Y, Y->R and no change; any other transition, or Y->R after fewer than MIN_YEL yellow cycles, SHALL be a sequence fault.
REQ-016 Yellow counters: each direction SHALL have an 8-bit yellow-run counter that saturates, counts consecutive cycles of valid yellow, and clears on any non-yellow value.
REQ-017 Tracking: each direction's previous-value register SHALL update only on valid one-hot inputs, in all states.
REQ-018 In RUN, each out_* SHALL equal the corresponding in_* delayed by one cycle.
REQ-019 In RECOVER, all out_* SHALL be 100.
REQ-020 In RECOVER, conflict and invalid faults SHALL be detected, and sequence faults SHALL NOT be flagged.
REQ-021 RECOVER SHALL go to RUN after ALLRED_CYC cycles with no fault.
REQ-022 Any detected fault in RUN or RECOVER SHALL cause entry to FAULT on the next edge.
REQ-023 On FAULT entry, fault_code SHALL load the cause and fault_cnt SHALL increment.
REQ-024 When causes coincide, fault_code SHALL take the priority conflict > invalid > sequence.
REQ-025 In FAULT, all out_* SHALL flash, starting with FLASH_HALF cycles of 100 and then FLASH_HALF cycles of 000, repeating.
REQ-026 The flash SHALL restart from the 100 phase on every FAULT entry.
REQ-027 In FAULT, clr_fault SHALL move the block to RECOVER on the next edge only if in that same cycle the inputs are valid one-hot and conflict-free; otherwise clr_fault SHALL be ignored.
REQ-028 clr_fault SHALL have no effect outside FAULT.
REQ-029 fault SHALL deassert on exit to RECOVER, while fault_code SHALL hold its value until the next FAULT entry.
REQ-030 A new fault in FAULT SHALL NOT increment fault_cnt or change fault_code.

Reset
REQ-031 While rst=0, the block SHALL asynchronously force state=RECOVER, all out_*=100, fault=0, fault_code=00 and fault_cnt=0.
REQ-032 While rst=0, the block SHALL also force the RECOVER and flash counters to 0, all previous-value registers to 100, and all yellow counters to 0.
REQ-033 Reset asserted during any state SHALL abort that state immediately.
REQ-034 After rst rises, the block SHALL begin a full ALLRED_CYC RECOVER.

Verification
REQ-035 Scenario: release rst with all inputs 100 -> outputs 100 for 8 cycles, then RUN, and an input change to in_M1=001 appears on out_M1 exactly one cycle later.
REQ-036 Scenario: in RUN, in_M1=001 and in_S=001 for one cycle -> next edge gives fault=1, fault_code=01, fault_cnt=1, and outputs 100 x4 cycles then 000 x4 cycles.
REQ-037 Scenario: in_MT=011 for 1 cycle then 100 -> no fault; in_MT=011 for 2 cycles -> FAULT with fault_code=10.
REQ-038 Scenario: in_M2 goes G then Y for 2 cycles then R -> fault_code=11; the same sequence with Y for 3 cycles -> no fault.
REQ-039 Scenario: in FAULT, clr_fault pulsed while in_S=001 and in_M1=001 -> remains in FAULT; clr_fault pulsed with all inputs 100 -> RECOVER, fault=0, fault_code still set, and RUN after 8 cycles.
REQ-040 Scenario: rst driven low mid-flash -> all outputs are 100 and fault_cnt=0 immediately, before the next clk edge.
